angle_servo_ctrl: RTL and testbench
===================================

# angle_servo_ctrl

Parametrised, multi-channel closed-loop angle controller for the swerve-drive rotation motors. It holds a target angle per channel and services active channels round-robin through one shared angle-sensor request port. For each serviced channel it computes the shortest-path wrap-around error and issues a direction and saturated PWM ratio to that channel's PWM generator. It replaces the single-channel, fixed-width controller and adds multi-channel operation, direction output, a deadband, ratio clamping and a sensor timeout.

## Interface
- NUM_CH, 4: number of motor channels (1..8).
- ANGLE_W, 12: angle width; full circle = 2^ANGLE_W counts.
- PWM_W, 8: PWM ratio width.
- DEADBAND, 8: |error| ≤ DEADBAND counts means the channel is on target.
- KP_SHIFT, 2: proportional gain; raw ratio = |error| >> KP_SHIFT.
- MIN_RATIO, 16: lowest non-zero ratio issued.
- SENSOR_TIMEOUT, 1024: maximum number of cycles to wait for sensor_ack.

- clock  in  1  main clock
- reset_n  in  1  asynchronous, active-low reset
- target_angle  in  NUM_CH*ANGLE_W  per-channel target; channel c occupies bits [c*ANGLE_W +: ANGLE_W]
- angle_update  in  NUM_CH  1-cycle pulse; latches target_angle[c] and marks channel c active
- angle_done  out  NUM_CH  1-cycle pulse when channel c reaches the deadband
- busy  out  1  high when any channel is active or the FSM is not in IDLE
- sensor_req  out  1  angle read request; held high until sensor_ack or timeout
- sensor_ch  out  $clog2(NUM_CH) (min 1)  channel being read; stable while sensor_req is high
- sensor_ack  in  1  1-cycle pulse; sensor_angle is valid in the same cycle
- sensor_angle  in  ANGLE_W  measured angle
- sensor_fault  out  1  1-cycle pulse on timeout
- pwm_enable  out  NUM_CH  per-channel PWM output enable
- pwm_dir  out  NUM_CH  1 = positive (increasing angle) rotation
- pwm_ratio  out  NUM_CH*PWM_W  per-channel high-time
- pwm_update  out  NUM_CH  held high until the matching pwm_done
- pwm_done  in  NUM_CH  1-cycle pulse; the new ratio has been applied

## Operation
- Per-channel registers: tgt[c] and active[c]. An angle_update[c] pulse loads tgt[c] and sets active[c] in any state.
- FSM states: IDLE, REQ, CALC, WAIT_PWM.
- IDLE: if any channel is active, select the first active channel searching upward from last_ch+1 (modulo NUM_CH), then go to REQ. Otherwise stay in IDLE.
- REQ: drive sensor_req=1 and sensor_ch=ch.
  - On sensor_ack: capture sensor_angle and go to CALC.
  - When the timeout counter reaches SENSOR_TIMEOUT: drop the request, clear pwm_enable[ch], pulse sensor_fault, keep active[ch] set, and go to IDLE.
- CALC (one cycle):
  - err = tgt − angle, computed modulo 2^ANGLE_W and read as signed.
  - mag = |err|. When err = −2^(ANGLE_W−1), set mag = 2^(ANGLE_W−1) and dir = 1.
  - If mag ≤ DEADBAND: pwm_enable[ch]=0, pwm_ratio[ch]=0, pulse angle_done[ch], clear active[ch], go to IDLE.
  - Otherwise: pwm_ratio[ch] = clamp(mag >> KP_SHIFT, MIN_RATIO, 2^PWM_W−1), pwm_dir[ch] = ~err sign (dir=1 when err > 0), pwm_enable[ch]=1, raise pwm_update[ch], go to WAIT_PWM.
- WAIT_PWM: hold pwm_update[ch] until pwm_done[ch], then drop it, record last_ch=ch, and go to IDLE.
- An angle_update[c] arriving in the same cycle as a done decision for channel c has priority: the new target is stored, active[c] stays set, and angle_done[c] is suppressed.
- Outputs of channels that are not being serviced hold their last values.

## Timing
- Reset values: all outputs 0. Internal state: active=0, last_ch=NUM_CH−1, FSM in IDLE.
- Latency from an angle_update edge (in IDLE) to sensor_req high is 2 cycles.
- The CALC result appears on outputs 1 cycle after sensor_ack. angle_done and pwm_update assert in that same cycle.
- After pwm_done, the FSM is back in IDLE on the next cycle. The next sensor_req follows 1 cycle after that.
- pwm_done or sensor_ack arriving in a state that is not waiting for it is ignored.
- The timeout counter clears on entry to REQ.
- Asserting reset_n low mid-operation immediately clears all outputs and state.

## Structure
- Shared package angle_servo_pkg holds:
  - the FSM state encoding,
  - a clog2 helper,
  - the default parameter constants.
- One natural sub-module, angle_error_calc: purely combinational. Inputs are tgt and angle; outputs are dir, mag, ratio and within_deadband.

## Test plan
- Ch0: target 100, sensor 40 → err +60, 60>>2=15 clamps up, so ratio 16, dir 1, enable 1. pwm_update held until pwm_done.
- Wrap-around: ch1 target 10, sensor 4090 → err +16, dir 1, ratio 16. Ch1 target 4000, sensor 100 → err −196, dir 0, ratio 49.
- Deadband: ch2 target 100, sensor 95 → angle_done[2] pulses once, enable 0, ratio 0, active cleared. busy falls once no other channel is active.
- Round-robin: ch0 and ch2 both active, sensor always far from target → sensor_ch sequence is 0,2,0,2.
- Timeout: no sensor_ack for 1024 cycles → sensor_fault pulse, sensor_req drops, pwm_enable[ch]=0, and the channel is retried.
- Reset asserted while in REQ and while in WAIT_PWM → all outputs 0 immediately. No request after release until a new angle_update.

Source files
------------

// File: rtl/angle_servo_pkg.sv
// Shared definitions for the swerve rotation angle controller: FSM encoding,
// default parameter values and a width helper.
package angle_servo_pkg;

  localparam int DEF_NUM_CH         = 4;
  localparam int DEF_ANGLE_W        = 12;
  localparam int DEF_PWM_W          = 8;
  localparam int DEF_DEADBAND       = 8;
  localparam int DEF_KP_SHIFT       = 2;
  localparam int DEF_MIN_RATIO      = 16;
  localparam int DEF_SENSOR_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_CALC     = 2'd2,
    S_WAIT_PWM = 2'd3
  } state_e;

  // Bits needed to hold values 0..v-1, never less than one bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/angle_servo_ctrl_angle_error_calc.sv
// Shortest-path wrap-around error between target and measured angle, turned
// into a rotation direction and a clamped proportional PWM ratio.
module angle_error_calc
  import angle_servo_pkg::*;
#(
  parameter int ANGLE_W   = DEF_ANGLE_W,
  parameter int PWM_W     = DEF_PWM_W,
  parameter int DEADBAND  = DEF_DEADBAND,
  parameter int KP_SHIFT  = DEF_KP_SHIFT,
  parameter int MIN_RATIO = DEF_MIN_RATIO
) (
  input  logic [ANGLE_W-1:0] tgt_i,
  input  logic [ANGLE_W-1:0] angle_i,
  output logic               dir_o,
  output logic [ANGLE_W-1:0] mag_o,
  output logic [PWM_W-1:0]   ratio_o,
  output logic               within_deadband_o
);

  localparam int RW = (ANGLE_W > PWM_W) ? ANGLE_W : PWM_W;
  localparam logic [RW-1:0] MAX_R = RW'((1 << PWM_W) - 1);
  localparam logic [RW-1:0] MIN_R = RW'(MIN_RATIO);
  localparam logic [ANGLE_W-1:0] HALF_TURN = {1'b1, {(ANGLE_W-1){1'b0}}};

  logic [ANGLE_W-1:0] err;
  logic [RW-1:0]      raw;

  always_comb begin
    err = tgt_i - angle_i;
    // A half-turn error negates to itself; it is read as +half turn, positive direction.
    if (err[ANGLE_W-1]) begin
      mag_o = ~err + 1'b1;
      dir_o = (err == HALF_TURN);
    end else begin
      mag_o = err;
      dir_o = 1'b1;
    end
    within_deadband_o = (mag_o <= ANGLE_W'(DEADBAND));
    raw = RW'(mag_o >> KP_SHIFT);
    if (raw > MAX_R)      ratio_o = MAX_R[PWM_W-1:0];
    else if (raw < MIN_R) ratio_o = MIN_R[PWM_W-1:0];
    else                  ratio_o = raw[PWM_W-1:0];
  end

endmodule

// File: rtl/angle_servo_ctrl.sv
// Multi-channel closed-loop angle controller: round-robin sensor reads through
// one shared port, per-channel direction and saturated PWM ratio outputs.
module angle_servo_ctrl
  import angle_servo_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int ANGLE_W        = DEF_ANGLE_W,
  parameter int PWM_W          = DEF_PWM_W,
  parameter int DEADBAND       = DEF_DEADBAND,
  parameter int KP_SHIFT       = DEF_KP_SHIFT,
  parameter int MIN_RATIO      = DEF_MIN_RATIO,
  parameter int SENSOR_TIMEOUT = DEF_SENSOR_TIMEOUT,
  localparam int CH_W          = clog2_min1(NUM_CH)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_CH*ANGLE_W-1:0] target_angle,
  input  logic [NUM_CH-1:0]         angle_update,
  output logic [NUM_CH-1:0]         angle_done,
  output logic                      busy,
  output logic                      sensor_req,
  output logic [CH_W-1:0]           sensor_ch,
  input  logic                      sensor_ack,
  input  logic [ANGLE_W-1:0]        sensor_angle,
  output logic                      sensor_fault,
  output logic [NUM_CH-1:0]         pwm_enable,
  output logic [NUM_CH-1:0]         pwm_dir,
  output logic [NUM_CH*PWM_W-1:0]   pwm_ratio,
  output logic [NUM_CH-1:0]         pwm_update,
  input  logic [NUM_CH-1:0]         pwm_done,
  output state_e                    dbg_state,
  output logic [ANGLE_W-1:0]        dbg_mag
);

  localparam int TMR_W = clog2_min1(SENSOR_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_END = TMR_W'(SENSOR_TIMEOUT);

  state_e                    state_q, state_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [CH_W-1:0]           last_ch_q, last_ch_d;
  logic [TMR_W-1:0]          timer_q, timer_d;
  logic [NUM_CH-1:0]         active_q, active_d;
  logic [ANGLE_W-1:0]        tgt_q [NUM_CH];
  logic [ANGLE_W-1:0]        tgt_d [NUM_CH];
  logic                      hit_q, hit_d;
  logic [ANGLE_W-1:0]        mag_q, mag_d;
  logic [NUM_CH-1:0]         en_q, en_d;
  logic [NUM_CH-1:0]         dir_q, dir_d;
  logic [NUM_CH*PWM_W-1:0]   ratio_q, ratio_d;
  logic [NUM_CH-1:0]         upd_q, upd_d;
  logic [NUM_CH-1:0]         done_q, done_d;
  logic                      fault_q, fault_d;

  logic [CH_W-1:0]           next_ch;
  logic                      found;
  logic                      calc_dir;
  logic [ANGLE_W-1:0]        calc_mag;
  logic [PWM_W-1:0]          calc_ratio;
  logic                      calc_within;

  // The error is evaluated from sensor_angle in the ack cycle so the result is
  // already registered on the outputs while the FSM sits in CALC.
  angle_error_calc #(
    .ANGLE_W   (ANGLE_W),
    .PWM_W     (PWM_W),
    .DEADBAND  (DEADBAND),
    .KP_SHIFT  (KP_SHIFT),
    .MIN_RATIO (MIN_RATIO)
  ) u_calc (
    .tgt_i             (tgt_q[ch_q]),
    .angle_i           (sensor_angle),
    .dir_o             (calc_dir),
    .mag_o             (calc_mag),
    .ratio_o           (calc_ratio),
    .within_deadband_o (calc_within)
  );

  always_comb begin : next_ch_sel
    next_ch = last_ch_q;
    found   = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!found && active_q[(int'(last_ch_q) + i) % NUM_CH]) begin
        next_ch = CH_W'((int'(last_ch_q) + i) % NUM_CH);
        found   = 1'b1;
      end
    end
  end

  always_comb begin : fsm_next
    state_d   = state_q;
    ch_d      = ch_q;
    last_ch_d = last_ch_q;
    timer_d   = timer_q;
    active_d  = active_q;
    tgt_d     = tgt_q;
    hit_d     = hit_q;
    mag_d     = mag_q;
    en_d      = en_q;
    dir_d     = dir_q;
    ratio_d   = ratio_q;
    upd_d     = upd_q;
    done_d    = '0;
    fault_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|active_q) begin
          ch_d    = next_ch;
          timer_d = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (timer_q == TMR_END) begin
          fault_d    = 1'b1;
          en_d[ch_q] = 1'b0;
          state_d    = S_IDLE;
        end else if (sensor_ack) begin
          hit_d = calc_within;
          mag_d = calc_mag;
          if (calc_within) begin
            en_d[ch_q]                 = 1'b0;
            ratio_d[ch_q*PWM_W +: PWM_W] = '0;
            active_d[ch_q]             = 1'b0;
            done_d[ch_q]               = 1'b1;
          end else begin
            en_d[ch_q]                 = 1'b1;
            dir_d[ch_q]                = calc_dir;
            ratio_d[ch_q*PWM_W +: PWM_W] = calc_ratio;
            upd_d[ch_q]                = 1'b1;
          end
          state_d = S_CALC;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_CALC: begin
        state_d = hit_q ? S_IDLE : S_WAIT_PWM;
      end
      S_WAIT_PWM: begin
        if (pwm_done[ch_q]) begin
          upd_d[ch_q] = 1'b0;
          last_ch_d   = ch_q;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A fresh target beats a same-cycle on-target decision for that channel.
    for (int c = 0; c < NUM_CH; c++) begin
      if (angle_update[c]) begin
        tgt_d[c]    = target_angle[c*ANGLE_W +: ANGLE_W];
        active_d[c] = 1'b1;
        done_d[c]   = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      last_ch_q <= CH_W'(NUM_CH - 1);
      timer_q   <= '0;
      active_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) tgt_q[c] <= '0;
      hit_q     <= 1'b0;
      mag_q     <= '0;
      en_q      <= '0;
      dir_q     <= '0;
      ratio_q   <= '0;
      upd_q     <= '0;
      done_q    <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      last_ch_q <= last_ch_d;
      timer_q   <= timer_d;
      active_q  <= active_d;
      tgt_q     <= tgt_d;
      hit_q     <= hit_d;
      mag_q     <= mag_d;
      en_q      <= en_d;
      dir_q     <= dir_d;
      ratio_q   <= ratio_d;
      upd_q     <= upd_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
    end
  end

  // Request drops in the timeout cycle so it is high for exactly SENSOR_TIMEOUT cycles.
  assign sensor_req   = (state_q == S_REQ) && (timer_q != TMR_END);
  assign sensor_ch    = ch_q;
  assign busy         = (|active_q) || (state_q != S_IDLE);
  assign angle_done   = done_q;
  assign sensor_fault = fault_q;
  assign pwm_enable   = en_q;
  assign pwm_dir      = dir_q;
  assign pwm_ratio    = ratio_q;
  assign pwm_update   = upd_q;
  assign dbg_state    = state_q;
  assign dbg_mag      = mag_q;

endmodule

// File: tb/tb_angle_servo_ctrl.sv
// Directed bench for angle_servo_ctrl with hand-computed expected values.
module tb_angle_servo_ctrl;
  import angle_servo_pkg::*;

  logic         clock;
  logic         reset_n;
  logic [47:0]  target_angle;
  logic [3:0]   angle_update;
  logic [3:0]   angle_done;
  logic         busy;
  logic         sensor_req;
  logic [1:0]   sensor_ch;
  logic         sensor_ack;
  logic [11:0]  sensor_angle;
  logic         sensor_fault;
  logic [3:0]   pwm_enable;
  logic [3:0]   pwm_dir;
  logic [31:0]  pwm_ratio;
  logic [3:0]   pwm_update;
  logic [3:0]   pwm_done;
  state_e       dbg_state;
  logic [11:0]  dbg_mag;

  int checks;
  int failures;

  angle_servo_ctrl dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .target_angle (target_angle),
    .angle_update (angle_update),
    .angle_done   (angle_done),
    .busy         (busy),
    .sensor_req   (sensor_req),
    .sensor_ch    (sensor_ch),
    .sensor_ack   (sensor_ack),
    .sensor_angle (sensor_angle),
    .sensor_fault (sensor_fault),
    .pwm_enable   (pwm_enable),
    .pwm_dir      (pwm_dir),
    .pwm_ratio    (pwm_ratio),
    .pwm_update   (pwm_update),
    .pwm_done     (pwm_done),
    .dbg_state    (dbg_state),
    .dbg_mag      (dbg_mag)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset_n      = 1'b0;
    target_angle = '0;
    angle_update = '0;
    sensor_ack   = 1'b0;
    sensor_angle = '0;
    pwm_done     = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  function automatic logic [7:0] ratio_of(input int c);
    return pwm_ratio[c*8 +: 8];
  endfunction

  // Drivers
  task automatic update_ch(input int c, input logic [11:0] tgt);
    target_angle[c*12 +: 12] = tgt;
    angle_update = 4'b0001 << c;
    tick();
    angle_update = '0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (sensor_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic ack_sensor(input logic [11:0] ang);
    sensor_angle = ang;
    sensor_ack   = 1'b1;
    tick();
    sensor_ack   = 1'b0;
  endtask

  task automatic give_pwm_done(input int c);
    tick();
    pwm_done = 4'b0001 << c;
    tick();
    pwm_done = '0;
  endtask

  // Tests
  task automatic test_reset();
    apply_reset();
    checks++; if ({angle_done, busy, sensor_req, sensor_fault, pwm_enable, pwm_dir, pwm_update} !== '0) begin failures++; $display("FAIL reset_ctrl_outputs got=%h exp=0", {angle_done, busy, sensor_req, sensor_fault, pwm_enable, pwm_dir, pwm_update}); end
    checks++; if (pwm_ratio !== 32'd0) begin failures++; $display("FAIL reset_ratio got=%h exp=0", pwm_ratio); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_basic_ch0();
    bit ok;
    update_ch(0, 12'd100);
    checks++; if (sensor_req !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", sensor_req); end
    tick();
    checks++; if (sensor_req !== 1'b1 || sensor_ch !== 2'd0) begin failures++; $display("FAIL latency_req got=%b/%0d exp=1/0", sensor_req, sensor_ch); end
    ack_sensor(12'd40);
    checks++; if (pwm_enable[0] !== 1'b1 || pwm_dir[0] !== 1'b1 || ratio_of(0) !== 8'd16) begin failures++; $display("FAIL ch0_calc got=en%b dir%b r%0d exp=en1 dir1 r16", pwm_enable[0], pwm_dir[0], ratio_of(0)); end
    checks++; if (pwm_update[0] !== 1'b1 || angle_done !== 4'd0) begin failures++; $display("FAIL ch0_update got=upd%b done%h exp=upd1 done0", pwm_update[0], angle_done); end
    repeat (3) tick();
    checks++; if (pwm_update[0] !== 1'b1 || dbg_state !== S_WAIT_PWM) begin failures++; $display("FAIL ch0_hold got=upd%b st%0d exp=upd1 st3", pwm_update[0], dbg_state); end
    give_pwm_done(0);
    checks++; if (pwm_update[0] !== 1'b0 || dbg_state !== S_IDLE) begin failures++; $display("FAIL ch0_pwm_done got=upd%b st%0d exp=upd0 st0", pwm_update[0], dbg_state); end
    tick();
    checks++; if (sensor_req !== 1'b1 || sensor_ch !== 2'd0) begin failures++; $display("FAIL ch0_reservice got=%b/%0d exp=1/0", sensor_req, sensor_ch); end
    wait_req(ok);
    ack_sensor(12'd100);
    checks++; if (angle_done !== 4'b0001 || pwm_enable[0] !== 1'b0 || ratio_of(0) !== 8'd0) begin failures++; $display("FAIL ch0_on_target got=done%h en%b r%0d exp=done1 en0 r0", angle_done, pwm_enable[0], ratio_of(0)); end
    tick();
    checks++; if (angle_done !== 4'd0 || busy !== 1'b0) begin failures++; $display("FAIL ch0_idle got=done%h busy%b exp=done0 busy0", angle_done, busy); end
  endtask

  task automatic test_wrap();
    bit ok;
    update_ch(1, 12'd10);
    wait_req(ok);
    checks++; if (!ok || sensor_ch !== 2'd1) begin failures++; $display("FAIL wrap_pos_req got=%b/%0d exp=1/1", ok, sensor_ch); end
    ack_sensor(12'd4090);
    checks++; if (pwm_dir[1] !== 1'b1 || ratio_of(1) !== 8'd16 || dbg_mag !== 12'd16) begin failures++; $display("FAIL wrap_pos got=dir%b r%0d mag%0d exp=dir1 r16 mag16", pwm_dir[1], ratio_of(1), dbg_mag); end
    give_pwm_done(1);
    wait_req(ok);
    ack_sensor(12'd10);
    tick();
    update_ch(1, 12'd4000);
    wait_req(ok);
    checks++; if (!ok || sensor_ch !== 2'd1) begin failures++; $display("FAIL wrap_neg_req got=%b/%0d exp=1/1", ok, sensor_ch); end
    ack_sensor(12'd100);
    checks++; if (pwm_dir[1] !== 1'b0 || ratio_of(1) !== 8'd49 || pwm_enable[1] !== 1'b1) begin failures++; $display("FAIL wrap_neg got=dir%b r%0d en%b exp=dir0 r49 en1", pwm_dir[1], ratio_of(1), pwm_enable[1]); end
    give_pwm_done(1);
    wait_req(ok);
    ack_sensor(12'd4000);
    tick();
  endtask

  task automatic test_deadband();
    bit ok;
    update_ch(2, 12'd100);
    wait_req(ok);
    ack_sensor(12'd95);
    checks++; if (angle_done !== 4'b0100 || pwm_enable[2] !== 1'b0 || ratio_of(2) !== 8'd0) begin failures++; $display("FAIL deadband_done got=done%h en%b r%0d exp=done4 en0 r0", angle_done, pwm_enable[2], ratio_of(2)); end
    tick();
    checks++; if (angle_done !== 4'd0 || busy !== 1'b0) begin failures++; $display("FAIL deadband_once got=done%h busy%b exp=0 0", angle_done, busy); end
    // |err| of exactly DEADBAND is on target
    update_ch(3, 12'd108);
    wait_req(ok);
    ack_sensor(12'd100);
    checks++; if (angle_done !== 4'b1000) begin failures++; $display("FAIL deadband_edge got=%h exp=8", angle_done); end
    tick();
    // half-turn error: positive direction, ratio saturates
    update_ch(3, 12'd2048);
    wait_req(ok);
    ack_sensor(12'd0);
    checks++; if (pwm_dir[3] !== 1'b1 || ratio_of(3) !== 8'd255 || dbg_mag !== 12'd2048) begin failures++; $display("FAIL half_turn got=dir%b r%0d mag%0d exp=dir1 r255 mag2048", pwm_dir[3], ratio_of(3), dbg_mag); end
    give_pwm_done(3);
    wait_req(ok);
    ack_sensor(12'd1100);
    checks++; if (pwm_dir[3] !== 1'b1 || ratio_of(3) !== 8'd237) begin failures++; $display("FAIL mid_ratio got=dir%b r%0d exp=dir1 r237", pwm_dir[3], ratio_of(3)); end
    give_pwm_done(3);
    wait_req(ok);
    ack_sensor(12'd2047);
    tick();
    // stray ack while idle is ignored
    sensor_ack = 1'b1;
    tick();
    sensor_ack = 1'b0;
    tick();
    checks++; if (dbg_state !== S_IDLE || busy !== 1'b0) begin failures++; $display("FAIL stray_ack got=st%0d busy%b exp=0 0", dbg_state, busy); end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [1:0] seq [4];
    apply_reset();
    target_angle = '0;
    angle_update = 4'b0101;
    tick();
    angle_update = '0;
    for (int n = 0; n < 4; n++) begin
      wait_req(ok);
      seq[n] = ok ? sensor_ch : 2'd3;
      ack_sensor(12'd2048);
      give_pwm_done(int'(sensor_ch));
    end
    checks++; if (seq[0] !== 2'd0 || seq[1] !== 2'd2 || seq[2] !== 2'd0 || seq[3] !== 2'd2) begin failures++; $display("FAIL round_robin got=%0d,%0d,%0d,%0d exp=0,2,0,2", seq[0], seq[1], seq[2], seq[3]); end
    wait_req(ok);
    ack_sensor(12'd0);
    tick();
    wait_req(ok);
    ack_sensor(12'd0);
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_drain got=%b exp=0", busy); end
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt;
    update_ch(1, 12'd500);
    wait_req(ok);
    ack_sensor(12'd0);
    checks++; if (pwm_enable[1] !== 1'b1 || ratio_of(1) !== 8'd125) begin failures++; $display("FAIL to_pre got=en%b r%0d exp=en1 r125", pwm_enable[1], ratio_of(1)); end
    give_pwm_done(1);
    wait_req(ok);
    cnt = 0;
    while (sensor_req && cnt < 1100) begin
      cnt++;
      tick();
    end
    checks++; if (cnt !== 1024 || sensor_fault !== 1'b0) begin failures++; $display("FAIL to_req_len got=%0d/%b exp=1024/0", cnt, sensor_fault); end
    tick();
    checks++; if (sensor_fault !== 1'b1 || pwm_enable[1] !== 1'b0 || sensor_req !== 1'b0) begin failures++; $display("FAIL to_fault got=f%b en%b req%b exp=f1 en0 req0", sensor_fault, pwm_enable[1], sensor_req); end
    tick();
    checks++; if (sensor_fault !== 1'b0 || sensor_req !== 1'b1 || sensor_ch !== 2'd1) begin failures++; $display("FAIL to_retry got=f%b req%b ch%0d exp=f0 req1 ch1", sensor_fault, sensor_req, sensor_ch); end
    ack_sensor(12'd500);
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    update_ch(0, 12'd1000);
    wait_req(ok);
    checks++; if (dbg_state !== S_REQ) begin failures++; $display("FAIL rst_req_pre got=%0d exp=1", dbg_state); end
    reset_n = 1'b0;
    #1;
    checks++; if ({sensor_req, busy, pwm_enable, pwm_update} !== '0 || dbg_state !== S_IDLE) begin failures++; $display("FAIL rst_in_req got=%h st%0d exp=0 st0", {sensor_req, busy, pwm_enable, pwm_update}, dbg_state); end
    repeat (2) tick();
    reset_n = 1'b1;
    update_ch(0, 12'd1000);
    wait_req(ok);
    ack_sensor(12'd0);
    tick();
    checks++; if (dbg_state !== S_WAIT_PWM || pwm_update[0] !== 1'b1 || ratio_of(0) !== 8'd250) begin failures++; $display("FAIL rst_wait_pre got=st%0d upd%b r%0d exp=st3 upd1 r250", dbg_state, pwm_update[0], ratio_of(0)); end
    reset_n = 1'b0;
    #1;
    checks++; if ({pwm_update, pwm_enable, pwm_dir, angle_done, busy} !== '0 || pwm_ratio !== 32'd0) begin failures++; $display("FAIL rst_in_wait got=%h r%h exp=0", {pwm_update, pwm_enable, pwm_dir, angle_done, busy}, pwm_ratio); end
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (6) tick();
    checks++; if (sensor_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_no_req got=req%b busy%b exp=0 0", sensor_req, busy); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic_ch0();
    test_wrap();
    test_deadband();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
